dmem_responder: RTL and testbench

- Memory-side responder for the LSU load and store channels driven by the backend mem stage.
- Accepts one request at a time on either channel and performs it against an internal 64-bit-wide word array.
- Returns a one-cycle operation_done pulse after a fixed latency; load data comes back with the done pulse.
- Stands in for L1 D$/memory in simulation and early bring-up. It is the slave end of the opload_*/opstore_* handshake.

---
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for the LSU load/store channels: one request at a time, fixed-latency done pulse.
// Optional DMEM_RANGE_CHECK_EN adds access_err and blocks out-of-range accesses instead of aliasing them.
module dmem_responder #(
  parameter int INDEX_W    = 19,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               opload_index_valid,
  input  logic [INDEX_W-1:0] opload_index,
  output logic               opload_index_ready,
  output logic [63:0]        opload_read_data,
  output logic               opload_operation_done,
  input  logic               opstore_index_valid,
  input  logic [INDEX_W-1:0] opstore_index,
  output logic               opstore_index_ready,
  input  logic [63:0]        opstore_write_mask,
  input  logic [63:0]        opstore_write_data,
  output logic               opstore_operation_done
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic               access_err
`endif
);

  // state   | meaning
  // IDLE    | accepting requests, store wins over load
  // BUSY_LD | load in flight, counting down latency
  // BUSY_ST | store in flight, counting down latency
  // RESP    | done pulse cycle, no accepts
  typedef enum logic [1:0] {IDLE, BUSY_LD, BUSY_ST, RESP} state_t;

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t               state;
  logic [3:0]           cnt;
  logic [INDEX_W-1:0]   lat_index;
  logic [63:0]          lat_mask;
  logic [63:0]          lat_data;
  logic [63:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] word_addr;
  logic                 in_range;
  logic                 resp_next;
  logic                 mem_we;

  assign word_addr = lat_index[DEPTH_LOG2-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (lat_index >> DEPTH_LOG2) == '0;
`else
  // Upper index bits alias onto the array.
  logic unused_idx_hi;
  assign unused_idx_hi = |lat_index[INDEX_W-1:DEPTH_LOG2];
  assign in_range      = 1'b1;
`endif

  assign opstore_index_ready = (state == IDLE) && !reset_n;
  assign opload_index_ready  = (state == IDLE) && !reset_n && !opstore_index_valid;

  assign resp_next = ((state == BUSY_LD) || (state == BUSY_ST)) && (cnt == '0);
  assign mem_we    = resp_next && (state == BUSY_ST) && in_range && !reset_n;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[word_addr] <= (mem[word_addr] & ~lat_mask) | (lat_data & lat_mask);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      state                  <= IDLE;
      cnt                    <= '0;
      opload_operation_done  <= 1'b0;
      opstore_operation_done <= 1'b0;
      opload_read_data       <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      access_err             <= 1'b0;
`endif
    end else begin
      opload_operation_done  <= 1'b0;
      opstore_operation_done <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      access_err             <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (opstore_index_valid) begin
            lat_index <= opstore_index;
            lat_mask  <= opstore_write_mask;
            lat_data  <= opstore_write_data;
            cnt       <= CNT_INIT;
            state     <= BUSY_ST;
          end else if (opload_index_valid) begin
            lat_index <= opload_index;
            cnt       <= CNT_INIT;
            state     <= BUSY_LD;
          end
        end
        BUSY_LD, BUSY_ST: begin
          if (resp_next) begin
            state <= RESP;
            if (state == BUSY_ST) begin
              opstore_operation_done <= 1'b1;
            end else begin
              opload_operation_done <= 1'b1;
              opload_read_data      <= in_range ? mem[word_addr] : 64'h0;
            end
`ifdef DMEM_RANGE_CHECK_EN
            access_err <= !in_range;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized load/store traffic
// checked against a word-array model of the memory.
module tb_dmem_responder;

  localparam int INDEX_W    = 19;
  localparam int DEPTH_LOG2 = 12;
  localparam int LATENCY    = 2;
  localparam int EXP_LAT    = LATENCY + 1;

  logic               clock;
  logic               reset_n;
  logic               opload_index_valid;
  logic [INDEX_W-1:0] opload_index;
  logic               opload_index_ready;
  logic [63:0]        opload_read_data;
  logic               opload_operation_done;
  logic               opstore_index_valid;
  logic [INDEX_W-1:0] opstore_index;
  logic               opstore_index_ready;
  logic [63:0]        opstore_write_mask;
  logic [63:0]        opstore_write_data;
  logic               opstore_operation_done;
`ifdef DMEM_RANGE_CHECK_EN
  logic               access_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic last_err;
  logic [63:0] mdl [1 << DEPTH_LOG2];

  dmem_responder #(.INDEX_W(INDEX_W), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .opload_index_valid     (opload_index_valid),
    .opload_index           (opload_index),
    .opload_index_ready     (opload_index_ready),
    .opload_read_data       (opload_read_data),
    .opload_operation_done  (opload_operation_done),
    .opstore_index_valid    (opstore_index_valid),
    .opstore_index          (opstore_index),
    .opstore_index_ready    (opstore_index_ready),
    .opstore_write_mask     (opstore_write_mask),
    .opstore_write_data     (opstore_write_data),
    .opstore_operation_done (opstore_operation_done)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .access_err             (access_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void mdl_store(input int idx, input logic [63:0] m, input logic [63:0] d);
    int w;
    w = idx % (1 << DEPTH_LOG2);
    mdl[w] = (mdl[w] & ~m) | (d & m);
  endfunction

  function automatic logic sample_err();
`ifdef DMEM_RANGE_CHECK_EN
    return access_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_store(input int idx, input logic [63:0] m, input logic [63:0] d,
                          output int lat, output bit ok);
    opstore_index       = INDEX_W'(idx);
    opstore_write_mask  = m;
    opstore_write_data  = d;
    opstore_index_valid = 1'b1;
    ok  = 0;
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (opstore_index_ready) begin ok = 1; break; end
    end
    if (!ok) begin opstore_index_valid = 1'b0; return; end
    @(posedge clock); #1;
    opstore_index_valid = 1'b0;
    opstore_index       = INDEX_W'($urandom);
    opstore_write_mask  = {$urandom, $urandom};
    opstore_write_data  = {$urandom, $urandom};
    ok = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (opstore_operation_done) begin lat = i; ok = 1; last_err = sample_err(); break; end
    end
  endtask

  task automatic do_load(input int idx, output logic [63:0] d, output int lat, output bit ok);
    opload_index       = INDEX_W'(idx);
    opload_index_valid = 1'b1;
    ok  = 0;
    lat = -1;
    d   = 'x;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (opload_index_ready) begin ok = 1; break; end
    end
    if (!ok) begin opload_index_valid = 1'b0; return; end
    @(posedge clock); #1;
    opload_index_valid = 1'b0;
    opload_index       = INDEX_W'($urandom);
    ok = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (opload_operation_done) begin
        lat = i; ok = 1; d = opload_read_data; last_err = sample_err(); break;
      end
    end
  endtask

  // Store launched at cycle 0, load raised at ld_delay and held until accepted.
  task automatic pair_run(input int st_idx, input logic [63:0] m, input logic [63:0] d,
                          input int ld_idx, input int ld_delay,
                          output int st_n, output int ld_n, output bit early,
                          output logic [63:0] ld_data);
    bit ld_taken, st_acc, ld_acc;
    int st_done_cyc;
    st_n = 0; ld_n = 0; early = 0; ld_data = 'x;
    ld_taken = 0; st_done_cyc = -1;
    opstore_index       = INDEX_W'(st_idx);
    opstore_write_mask  = m;
    opstore_write_data  = d;
    opstore_index_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == ld_delay) begin
        opload_index       = INDEX_W'(ld_idx);
        opload_index_valid = 1'b1;
      end
      @(negedge clock);
      st_acc = opstore_index_valid && opstore_index_ready;
      ld_acc = opload_index_valid && opload_index_ready;
      if (opstore_operation_done) begin st_n++; st_done_cyc = cyc; end
      if (opload_operation_done) begin ld_n++; ld_data = opload_read_data; end
      if (opload_index_ready && (st_done_cyc < 0 || st_done_cyc == cyc)) early = 1;
      @(posedge clock); #1;
      if (st_acc) begin
        opstore_index_valid = 1'b0;
        opstore_write_data  = {$urandom, $urandom};
      end
      if (ld_acc) begin
        opload_index_valid = 1'b0;
        ld_taken = 1;
      end
    end
    opload_index_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n             = 1'b1;
    opstore_index_valid = 1'b1;
    opload_index_valid  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({opload_index_ready, opstore_index_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {opload_index_ready, opstore_index_ready});
    end
    n_tests++;
    if ({opload_operation_done, opstore_operation_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_done: got %b expected 00", {opload_operation_done, opstore_operation_done});
    end
    n_tests++;
    if (opload_read_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", opload_read_data);
    end
    opstore_index_valid = 1'b0;
    opload_index_valid  = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({opload_index_ready, opstore_index_ready} !== 2'b11) begin
      n_fail++; $display("FAIL idle_ready: got %b expected 11", {opload_index_ready, opstore_index_ready});
    end
  endtask

  task automatic test_store_load();
    logic [63:0] d, held;
    int lat;
    bit ok;
    do_store(5, '1, 64'hDEAD_BEEF_0123_4567, lat, ok);
    mdl_store(5, '1, 64'hDEAD_BEEF_0123_4567);
    n_tests++;
    if (!ok || lat != EXP_LAT) begin
      n_fail++; $display("FAIL store_latency: got %0d (ok=%0d) expected %0d", lat, ok, EXP_LAT);
    end
    @(negedge clock);
    n_tests++;
    if (opstore_operation_done !== 1'b0) begin
      n_fail++; $display("FAIL store_done_pulse: got %b expected 0 one cycle after done", opstore_operation_done);
    end
    do_load(5, d, lat, ok);
    n_tests++;
    if (!ok || lat != EXP_LAT) begin
      n_fail++; $display("FAIL load_latency: got %0d (ok=%0d) expected %0d", lat, ok, EXP_LAT);
    end
    n_tests++;
    if (d !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++; $display("FAIL load_data: got %h expected DEADBEEF01234567", d);
    end
    held = d;
    repeat (3) @(negedge clock);
    n_tests++;
    if (opload_read_data !== held || opload_operation_done !== 1'b0) begin
      n_fail++; $display("FAIL load_data_held: got %h done=%b expected %h done=0",
                         opload_read_data, opload_operation_done, held);
    end
  endtask

  task automatic test_partial_mask();
    logic [63:0] d, r;
    int lat;
    bit ok;
    do_store(7, '1, '1, lat, ok);
    mdl_store(7, '1, '1);
    do_store(7, 64'h0000_0000_0000_FF00, 64'h0, lat, ok);
    mdl_store(7, 64'h0000_0000_0000_FF00, 64'h0);
    do_load(7, d, lat, ok);
    n_tests++;
    if (!ok || d !== 64'hFFFF_FFFF_FFFF_00FF) begin
      n_fail++; $display("FAIL partial_mask: got %h expected FFFFFFFFFFFF00FF", d);
    end
    r = {$urandom, $urandom};
    do_store(7, 64'h0, r, lat, ok);
    n_tests++;
    if (!ok || lat != EXP_LAT) begin
      n_fail++; $display("FAIL zero_mask_done: got lat %0d (ok=%0d) expected %0d", lat, ok, EXP_LAT);
    end
    do_load(7, d, lat, ok);
    n_tests++;
    if (d !== mdl[7]) begin
      n_fail++; $display("FAIL zero_mask_data: got %h expected %h", d, mdl[7]);
    end
  endtask

  task automatic test_simultaneous();
    int st_n, ld_n;
    bit early;
    logic [63:0] d;
    pair_run(1, '1, 64'h42, 1, 0, st_n, ld_n, early, d);
    mdl_store(1, '1, 64'h42);
    n_tests++;
    if (early) begin
      n_fail++; $display("FAIL sim_load_ready: got ready=1 before store completion expected 0");
    end
    n_tests++;
    if (st_n != 1 || ld_n != 1) begin
      n_fail++; $display("FAIL sim_done_count: got st=%0d ld=%0d expected 1 1", st_n, ld_n);
    end
    n_tests++;
    if (d !== 64'h42) begin
      n_fail++; $display("FAIL sim_load_data: got %h expected 42", d);
    end
  endtask

  task automatic test_back_to_back();
    int st_n, ld_n;
    bit early;
    logic [63:0] d, v;
    v = {$urandom, $urandom};
    pair_run(9, '1, v, 9, 1, st_n, ld_n, early, d);
    mdl_store(9, '1, v);
    n_tests++;
    if (early) begin
      n_fail++; $display("FAIL busy_load_ready: got ready=1 during store expected 0");
    end
    n_tests++;
    if (st_n != 1 || ld_n != 1) begin
      n_fail++; $display("FAIL busy_done_count: got st=%0d ld=%0d expected 1 1", st_n, ld_n);
    end
    n_tests++;
    if (d !== mdl[9]) begin
      n_fail++; $display("FAIL busy_load_data: got %h expected %h", d, mdl[9]);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] d;
    int lat, dn;
    bit ok;
    do_store(3, '1, 64'h0, lat, ok);
    mdl_store(3, '1, 64'h0);
    @(negedge clock);
    opstore_index       = INDEX_W'(3);
    opstore_write_mask  = '1;
    opstore_write_data  = 64'h1;
    opstore_index_valid = 1'b1;
    @(posedge clock); #1;
    opstore_index_valid = 1'b0;
    reset_n = 1'b1;
    dn = 0;
    @(negedge clock);
    dn += int'(opstore_operation_done) + int'(opload_operation_done);
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (8) begin
      @(negedge clock);
      dn += int'(opstore_operation_done) + int'(opload_operation_done);
    end
    n_tests++;
    if (dn != 0) begin
      n_fail++; $display("FAIL midop_no_done: got %0d done pulses expected 0", dn);
    end
    do_load(3, d, lat, ok);
    n_tests++;
    if (!ok || d !== 64'h0) begin
      n_fail++; $display("FAIL midop_no_write: got %h expected 0", d);
    end
  endtask

  task automatic test_index_range();
    logic [63:0] d, v, w;
    int lat;
    bit ok;
    v = {$urandom, $urandom};
    w = ~v;
    do_store(0, '1, v, lat, ok);
    mdl_store(0, '1, v);
`ifdef DMEM_RANGE_CHECK_EN
    do_store(4096, '1, w, lat, ok);
    n_tests++;
    if (!ok || last_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_store_err: got %b expected 1", last_err);
    end
    do_load(4096, d, lat, ok);
    n_tests++;
    if (!ok || d !== 64'h0 || last_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_load: got data %h err %b expected 0 and 1", d, last_err);
    end
    do_load(0, d, lat, ok);
    n_tests++;
    if (d !== v || last_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_no_alias: got data %h err %b expected %h and 0", d, last_err, v);
    end
`else
    do_store(4096, '1, w, lat, ok);
    mdl_store(4096, '1, w);
    do_load(0, d, lat, ok);
    n_tests++;
    if (!ok || d !== mdl[0]) begin
      n_fail++; $display("FAIL alias_store: got %h expected %h", d, mdl[0]);
    end
    do_load(4096 + 5, d, lat, ok);
    n_tests++;
    if (!ok || d !== mdl[5]) begin
      n_fail++; $display("FAIL alias_load: got %h expected %h", d, mdl[5]);
    end
`endif
  endtask

  task automatic test_random();
    logic [63:0] d, m, v;
    int lat, idx, w;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      do_store(32 + i, '1, v, lat, ok);
      mdl_store(32 + i, '1, v);
    end
    for (int n = 0; n < 60; n++) begin
      w   = 32 + int'($urandom_range(0, 15));
      idx = w;
`ifndef DMEM_RANGE_CHECK_EN
      idx = w + (int'($urandom_range(0, 127)) << DEPTH_LOG2);
`endif
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0:       m = '1;
          1:       m = '0;
          default: m = {$urandom, $urandom};
        endcase
        v = {$urandom, $urandom};
        do_store(idx, m, v, lat, ok);
        mdl_store(w, m, v);
        n_tests++;
        if (!ok || lat != EXP_LAT) begin
          n_fail++; $display("FAIL rnd_store_lat: op %0d got %0d expected %0d", n, lat, EXP_LAT);
        end
      end else begin
        do_load(idx, d, lat, ok);
        n_tests++;
        if (!ok || lat != EXP_LAT || d !== mdl[w]) begin
          n_fail++; $display("FAIL rnd_load: op %0d idx %0d got %h lat %0d expected %h lat %0d",
                             n, idx, d, lat, mdl[w], EXP_LAT);
        end
      end
    end
  endtask

  initial begin
    reset_n             = 1'b1;
    opload_index_valid  = 1'b0;
    opload_index        = '0;
    opstore_index_valid = 1'b0;
    opstore_index       = '0;
    opstore_write_mask  = '0;
    opstore_write_data  = '0;
    last_err            = 1'b0;
    test_reset();
    test_store_load();
    test_partial_mask();
    test_simultaneous();
    test_back_to_back();
    test_reset_midop();
    test_index_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
